// File: rtl/gcd_unit_if.sv
// Handshake bundle between the relprime controller (master) and gcd_unit (slave).
// The iter_count signal exists only when GCD_ITER_COUNT_EN is defined.
interface gcd_unit_if #(
   parameter int WIDTH = 16
`ifdef GCD_ITER_COUNT_EN
   , parameter int CNT_WIDTH = 16
`endif
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
`ifdef GCD_ITER_COUNT_EN
   logic [CNT_WIDTH-1:0] iter_count;

   modport master (output start, a_in, b_in, input busy, done, result, iter_count);
   modport slave  (input start, a_in, b_in, output busy, done, result, iter_count);
`else
   modport master (output start, a_in, b_in, input busy, done, result);
   modport slave  (input start, a_in, b_in, output busy, done, result);
`endif
endinterface

// File: rtl/gcd_unit.sv
// Iterative subtractive-Euclid GCD engine with a one-cycle done strobe.
// Define GCD_ITER_COUNT_EN to add the saturating subtraction-step counter (iter_count).
module gcd_unit #(
   parameter int WIDTH = 16
`ifdef GCD_ITER_COUNT_EN
   , parameter int CNT_WIDTH = 16
`endif
) (
   input logic       CLK,
   input logic       reset,
   gcd_unit_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] a_next;
   logic [WIDTH-1:0] b_next;
   logic [WIDTH-1:0] result_reg;
   logic [WIDTH-1:0] result_next;
   logic             done_reg;
   logic             done_next;
   logic             operand_zero;
   logic             regs_equal;
   logic             a_greater;

`ifdef GCD_ITER_COUNT_EN
   logic [CNT_WIDTH-1:0] count_reg;
   logic [CNT_WIDTH-1:0] count_next;
`endif

   assign operand_zero = (bus.a_in == '0) || (bus.b_in == '0);
   assign regs_equal   = (a_reg == b_reg);
   assign a_greater    = (a_reg > b_reg);

   always_ff @(posedge CLK) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.start && !operand_zero) state_next = RUN;
         RUN:  if (regs_equal)                 state_next = IDLE;
      endcase
   end

   // Zero operands finish straight from IDLE, so done never needs a RUN cycle for them.
   always_comb begin
      a_next      = a_reg;
      b_next      = b_reg;
      result_next = result_reg;
      done_next   = 1'b0;
`ifdef GCD_ITER_COUNT_EN
      count_next  = count_reg;
`endif
      case (state)
         IDLE: begin
            if (bus.start) begin
`ifdef GCD_ITER_COUNT_EN
               count_next = '0;
`endif
               if (operand_zero) begin
                  result_next = bus.a_in | bus.b_in;
                  done_next   = 1'b1;
               end else begin
                  a_next = bus.a_in;
                  b_next = bus.b_in;
               end
            end
         end
         RUN: begin
            if (regs_equal) begin
               result_next = a_reg;
               done_next   = 1'b1;
            end else begin
               if (a_greater) a_next = a_reg - b_reg;
               else           b_next = b_reg - a_reg;
`ifdef GCD_ITER_COUNT_EN
               if (count_reg != '1) count_next = count_reg + 1'b1;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         done_reg   <= 1'b0;
`ifdef GCD_ITER_COUNT_EN
         count_reg  <= '0;
`endif
      end else begin
         a_reg      <= a_next;
         b_reg      <= b_next;
         result_reg <= result_next;
         done_reg   <= done_next;
`ifdef GCD_ITER_COUNT_EN
         count_reg  <= count_next;
`endif
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = done_reg;
   assign bus.result = result_reg;
`ifdef GCD_ITER_COUNT_EN
   assign bus.iter_count = count_reg;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Scoreboard bench for gcd_unit: a division-based Euclid model predicts result,
// step count and done latency; a negedge monitor pops and compares on every done.
module tb_gcd_unit;

   typedef struct {
      int res;
      int iters;
      int due;
   } exp_t;

   logic CLK   = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   gcd_unit_if bus ();

   gcd_unit dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc = cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Subtractive Euclid performs sum(quotients)-1 subtractions before the operands meet.
   function automatic void refGcd(input int a, input int b, output int g, output int steps);
      int x, y, t, qsum;
      if (a == 0 || b == 0) begin
         g     = a | b;
         steps = 0;
      end else begin
         x = a; y = b; qsum = 0;
         while (y != 0) begin
            qsum += x / y;
            t = x % y;
            x = y;
            y = t;
         end
         g     = x;
         steps = qsum - 1;
      end
   endfunction

   task automatic applyStimulus(input int a, input int b);
      int   g, s;
      exp_t e;
      refGcd(a, b, g, s);
      e.res   = g;
      e.iters = s;
      e.due   = cyc + 1 + ((a == 0 || b == 0) ? 0 : 1 + s);
      sb.push_back(e);
      bus.start = 1'b1;
      bus.a_in  = a[15:0];
      bus.b_in  = b[15:0];
      @(posedge CLK);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic drainScoreboard(input int max_cycles, input string name);
      int n = 0;
      while (sb.size() != 0 && n < max_cycles) begin
         @(negedge CLK);
         #1;
         n++;
      end
      checkOutput({"pending_", name}, sb.size(), 0);
      sb.delete();
   endtask

   task automatic waitDone(input int max_cycles, input string name);
      int n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (bus.done !== 1'b1 && n < max_cycles);
      checkOutput({"done_seen_", name}, bus.done, 1);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", bus.done, 0);
         end else begin
            e = sb.pop_front();
            checkOutput("result", bus.result, e.res);
            checkOutput("done_cycle", cyc, e.due);
`ifdef GCD_ITER_COUNT_EN
            checkOutput("iter_count", bus.iter_count, e.iters);
`endif
         end
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ra, rb;
      bus.start = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;

      reset = 1'b1;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      reset = 1'b0;
      checkOutput("reset_busy", bus.busy, 0);
      checkOutput("reset_done", bus.done, 0);
      checkOutput("reset_result", bus.result, 0);
`ifdef GCD_ITER_COUNT_EN
      checkOutput("reset_iter_count", bus.iter_count, 0);
`endif

      applyStimulus(12, 8);
      checkOutput("busy_in_run", bus.busy, 1);
      drainScoreboard(100, "12_8");
      applyStimulus(5432, 2);
      drainScoreboard(6000, "5432_2");
      applyStimulus(5432, 3);
      drainScoreboard(6000, "5432_3");

      applyStimulus(0, 9);
      drainScoreboard(10, "0_9");
      applyStimulus(0, 0);
      drainScoreboard(10, "0_0");
      applyStimulus(7, 7);
      drainScoreboard(10, "7_7");
      repeat (3) @(negedge CLK);
      checkOutput("result_hold", bus.result, 7);
      checkOutput("done_one_cycle", bus.done, 0);

      // Extra start pulses while busy must neither resample operands nor add a done.
      applyStimulus(100, 75);
      repeat (2) begin
         @(negedge CLK);
         bus.start = 1'b1;
         bus.a_in  = 16'd3;
         bus.b_in  = 16'd3;
      end
      @(negedge CLK);
      bus.start = 1'b0;
      waitDone(50, "100_75");
      applyStimulus(9, 6);
      drainScoreboard(50, "9_6_b2b");

      applyStimulus(65535, 1);
      repeat (20) @(negedge CLK);
      reset = 1'b1;
      sb.delete();
      @(negedge CLK);
      checkOutput("midrun_reset_busy", bus.busy, 0);
      checkOutput("midrun_reset_done", bus.done, 0);
      checkOutput("midrun_reset_result", bus.result, 0);
`ifdef GCD_ITER_COUNT_EN
      checkOutput("midrun_reset_iter_count", bus.iter_count, 0);
`endif
      reset = 1'b0;
      repeat (5) @(negedge CLK);
      #1;
      applyStimulus(65535, 1);
      drainScoreboard(70000, "65535_1");

      for (int i = 0; i < 30; i++) begin
         ra = $urandom_range(0, 300);
         rb = $urandom_range(0, 300);
         applyStimulus(ra, rb);
         drainScoreboard(1000, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
